// File: rtl/rr_arbiter_3.sv
// Three-requester round-robin arbiter producing a registered one-hot mux select.
// Optional forced release after MAX_HOLD busy cycles is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_3 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] owner,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_n;
  logic [2:0] grant_n;
  logic [1:0] owner_n, last, last_n;
  logic       timeout_n;
  logic       pick_hit;
  logic [1:0] pick_idx;
  logic [1:0] cand1, cand2;
  logic       release_c;
  logic       limit_c;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold, hold_n;

  always_ff @(posedge clk) begin
    if (rst) hold <= '0;
    else     hold <= hold_n;
  end

  assign limit_c = (hold == HOLD_W'(MAX_HOLD - 1));
  assign hold_n  = (state == BUSY && !release_c && !limit_c) ? hold + HOLD_W'(1) : '0;
`else
  assign limit_c = 1'b0;
`endif

  // Priority order after the last owner: last+1, last+2, last.
  always_comb begin
    cand1    = nxt(last);
    cand2    = nxt(cand1);
    pick_hit = 1'b1;
    pick_idx = last;
    if      (req[cand1]) pick_idx = cand1;
    else if (req[cand2]) pick_idx = cand2;
    else if (req[last])  pick_idx = last;
    else                 pick_hit = 1'b0;
  end

  assign release_c = done || !req[owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 3'b000;
      owner   <= 2'd0;
      last    <= 2'd2;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      owner   <= owner_n;
      last    <= last_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    owner_n   = owner;
    last_n    = last;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          grant_n = 3'b001 << pick_idx;
          owner_n = pick_idx;
          state_n = BUSY;
        end
      end
      BUSY: begin
        // A normal release wins over the hold limit, so no timeout pulse then.
        if (release_c || limit_c) begin
          grant_n   = 3'b000;
          owner_n   = 2'd0;
          last_n    = owner;
          state_n   = IDLE;
          timeout_n = !release_c;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_3.sv
// Scoreboard bench for rr_arbiter_3: directed per-cycle vectors queue expected outputs,
// a monitor compares them just after each rising edge.
module tb_rr_arbiter_3;

  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       timeout;

  typedef struct {
    logic [2:0] g;
    logic [1:0] o;
    logic       t;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  rr_arbiter_3 #(.MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [2:0] rq, input logic d,
                      input logic [2:0] eg, input logic [1:0] eo, input logic et,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    e.g = eg; e.o = eo; e.t = et; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (grant !== e.g || owner !== e.o || timeout !== e.t) begin
          fails++;
          $display("FAIL %s: got grant=%b owner=%0d timeout=%b, want grant=%b owner=%0d timeout=%b",
                   e.nm, grant, owner, timeout, e.g, e.o, e.t);
        end
      end
    end
  end

  initial begin : stim
    int wait_cycles;
    // reset, then full rotation with done one cycle after each grant
    step(1, 3'b000, 0, 3'b000, 2'd0, 0, "reset");
    step(0, 3'b111, 0, 3'b001, 2'd0, 0, "rot_g0");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "rot_r0");
    step(0, 3'b111, 0, 3'b010, 2'd1, 0, "rot_g1");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "rot_r1");
    step(0, 3'b111, 0, 3'b100, 2'd2, 0, "rot_g2");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "rot_r2");
    step(0, 3'b111, 0, 3'b001, 2'd0, 0, "rot_g0b");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "rot_r0b");
    step(0, 3'b000, 0, 3'b000, 2'd0, 0, "idle_noreq");
    // single requester holds without done, drops after 5 cycles
    for (int i = 0; i < 5; i++) step(0, 3'b010, 0, 3'b010, 2'd1, 0, "hold_b");
    step(0, 3'b000, 0, 3'b000, 2'd0, 0, "drop_b");
    // other requests arriving during a grant are ignored; rotation continues at 1
    step(0, 3'b001, 0, 3'b001, 2'd0, 0, "own0_g");
    step(0, 3'b101, 0, 3'b001, 2'd0, 0, "own0_101");
    step(0, 3'b111, 0, 3'b001, 2'd0, 0, "own0_111");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "own0_rel");
    step(0, 3'b111, 0, 3'b010, 2'd1, 0, "rot_after0");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "rel1");
    step(0, 3'b000, 0, 3'b000, 2'd0, 0, "idle2");
    // done in IDLE is ignored
    step(0, 3'b000, 1, 3'b000, 2'd0, 0, "done_idle");
    step(0, 3'b100, 0, 3'b100, 2'd2, 0, "g2_after_done");
    // reset mid-grant aborts without a timeout pulse
    step(1, 3'b100, 0, 3'b000, 2'd0, 0, "rst_mid");
    step(0, 3'b111, 0, 3'b001, 2'd0, 0, "post_rst_g0");
    step(0, 3'b111, 1, 3'b000, 2'd0, 0, "post_rst_rel");
    // done and req drop together give a single release
    step(0, 3'b010, 0, 3'b010, 2'd1, 0, "dual_g1");
    step(0, 3'b000, 1, 3'b000, 2'd0, 0, "dual_rel");
    step(0, 3'b011, 0, 3'b001, 2'd0, 0, "dual_next");
    step(0, 3'b011, 0, 3'b001, 2'd0, 0, "dual_hold");
    step(0, 3'b011, 1, 3'b000, 2'd0, 0, "dual_rel2");
    step(0, 3'b011, 0, 3'b010, 2'd1, 0, "dual_g1b");
    // lone requester is re-granted back to back
    step(0, 3'b010, 1, 3'b000, 2'd0, 0, "b2b_rel");
    step(0, 3'b010, 0, 3'b010, 2'd1, 0, "b2b_regrant");
    step(0, 3'b000, 0, 3'b000, 2'd0, 0, "b2b_drop");
`ifdef RR_ARB_TIMEOUT_EN
    // forced release after HOLD busy cycles, then normal release at the limit wins
    for (int i = 0; i < int'(HOLD); i++) step(0, 3'b001, 0, 3'b001, 2'd0, 0, "to_hold");
    step(0, 3'b001, 0, 3'b000, 2'd0, 1, "to_pulse");
    step(0, 3'b001, 0, 3'b001, 2'd0, 0, "to_regrant");
    for (int i = 0; i < int'(HOLD) - 1; i++) step(0, 3'b001, 0, 3'b001, 2'd0, 0, "to_hold2");
    step(0, 3'b001, 1, 3'b000, 2'd0, 0, "to_precedence");
    step(0, 3'b000, 0, 3'b000, 2'd0, 0, "to_idle");
`endif
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
